// File: rtl/uart_rx_param.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_rx_param : parametrised async serial receiver, tick-enabled, 3x voting |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module uart_rx_param #(
    parameter int CLK_FREQ   = 24000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int ACC_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] RxD_data,
    output logic                 data_ready,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [SC_W-1:0] SC_M_M1 = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_M    = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0] SC_M_P1 = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [63:0]     INC_WIDE  =
        ((64'(BAUD) * 64'(OVERSAMPLE) * (64'd1 << ACC_W)) + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
    localparam logic [ACC_W:0]  INC = (ACC_W + 1)'(INC_WIDE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rxd_prev_q;
    logic [ACC_W:0]       acc_q;
    logic [SC_W-1:0]      sc_q, sc_d;
    logic [3:0]           bidx_q, bidx_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 commit_q, commit_d;

    logic rxd_s, tick, fall, bit_val, exp_par;
    logic [SC_W-1:0] sc_inc;

    assign rxd_s   = sync_q[1];
    assign tick    = acc_q[ACC_W];
    assign fall    = rxd_prev_q & ~rxd_s;
    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
    assign exp_par = (PARITY == 1) ? ~^shreg_q : ^shreg_q;
    assign sc_inc  = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            rxd_prev_q <= 1'b1;
            acc_q      <= '0;
            state_q    <= S_IDLE;
            sc_q       <= '0;
            bidx_q     <= '0;
            samp_q     <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], RxD};
            rxd_prev_q <= rxd_s;
            acc_q      <= {1'b0, acc_q[ACC_W-1:0]} + INC;
            state_q    <= state_d;
            sc_q       <= sc_d;
            bidx_q     <= bidx_d;
            samp_q     <= samp_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            commit_q   <= commit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        bidx_d   = bidx_q;
        samp_d   = samp_q;
        shreg_d  = shreg_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        commit_d = 1'b0;
        if (state_q == S_IDLE) begin
            sc_d = '0;
            // Edge-triggered arming: a line stuck low after a break never re-enters START.
            if (fall) begin
                state_d = S_START;
                bidx_d  = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
            end
        end else if (tick) begin
            sc_d = sc_inc;
            if (sc_q == SC_M_M1) samp_d[0] = rxd_s;
            if (sc_q == SC_M)    samp_d[1] = rxd_s;
            case (state_q)
                S_START: begin
                    if (sc_q == SC_M_P1 && bit_val) begin
                        state_d = S_IDLE;
                        sc_d    = '0;
                    end else if (sc_q == SC_LAST) begin
                        state_d = S_DATA;
                        bidx_d  = '0;
                    end
                end
                S_DATA: begin
                    if (sc_q == SC_M_P1) shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
                    if (sc_q == SC_LAST) begin
                        if (bidx_q == BIT_LAST) begin
                            bidx_d  = '0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bidx_d = bidx_q + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (sc_q == SC_M_P1) perr_d = (bit_val != exp_par);
                    if (sc_q == SC_LAST) begin
                        state_d = S_STOP;
                        bidx_d  = '0;
                    end
                end
                S_STOP: begin
                    if (sc_q == SC_M_P1) begin
                        if (!bit_val) ferr_d = 1'b1;
                        // Leave at mid-bit of the last stop bit so the next start edge is caught.
                        if (bidx_q == STOP_LAST) begin
                            commit_d = 1'b1;
                            state_d  = S_IDLE;
                            sc_d     = '0;
                        end
                    end else if (sc_q == SC_LAST) begin
                        bidx_d = bidx_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    sc_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RxD_data   <= '0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit_q) begin
                if (!data_ready || rx_ready) begin
                    RxD_data   <= shreg_q;
                    frame_err  <= ferr_q;
                    parity_err <= (PARITY != 0) ? perr_q : 1'b0;
                    data_ready <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_ready && rx_ready) begin
                data_ready <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
